imem_uart_loader: RTL and testbench

Boot-time writer for the instruction memory that the RV32 core fetches from. Receives a program image over a UART line (8N1), assembles little-endian 32-bit words and drives a single-cycle write port into instruction memory. Holds the core in reset until the whole image is written, then releases it.

---
 rtl/imem_uart_loader.sv | 269 ++++++++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// UART (8N1) boot loader for the instruction memory: receives a length-prefixed
// little-endian word image, writes it word by word and then releases the core.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_rst_n,
  output logic                  error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam longint unsigned CAPACITY = 64'd1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DATA,
    LD_DONE,
    LD_ERROR
  } ld_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          start_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    start_ok     = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end

      // Re-check the line at mid start bit so short low glitches are dropped.
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
            start_ok   = 1'b1;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      RX_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      RX_STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d    = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Image loader
  // ---------------------------------------------------------------------------
  ld_state_t             ld_state_q, ld_state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic [15:0]           len_new;
  logic                  last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q <= LD_LEN_LO;
      len_q      <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign len_new   = {shift_q, len_q[7:0]};
  assign last_word = (waddr_q == ADDR_WIDTH'(len_q - 16'd1));

  always_comb begin
    ld_state_d = ld_state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (ld_state_q)
      LD_LEN_LO: begin
        if (frame_err_q) begin
          ld_state_d = LD_ERROR;
        end else if (byte_valid_q) begin
          len_d[7:0] = shift_q;
          ld_state_d = LD_LEN_HI;
        end
      end

      LD_LEN_HI: begin
        if (frame_err_q) begin
          ld_state_d = LD_ERROR;
        end else if (byte_valid_q) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            ld_state_d = LD_DONE;
          end else if (64'(len_new) > CAPACITY) begin
            ld_state_d = LD_ERROR;
          end else begin
            ld_state_d = LD_DATA;
          end
        end
      end

      LD_DATA: begin
        if (we_q) begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          if (last_word) begin
            ld_state_d = LD_DONE;
          end
        end
        if (frame_err_q) begin
          ld_state_d = LD_ERROR;
        end else if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
          // Bytes 0..2 are staged; the 4th completes the word and writes it.
          case (byte_idx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              we_d    = 1'b1;
              wdata_d = {shift_q, word_q};
              waddr_d = word_idx_q;
            end
          endcase
        end
      end

      LD_DONE:  ld_state_d = LD_DONE;
      LD_ERROR: ld_state_d = LD_ERROR;
      default:  ld_state_d = LD_ERROR;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (ld_state_d == LD_DONE || ld_state_d == LD_ERROR) begin
      busy_d = 1'b0;
    end else if (start_ok) begin
      busy_d = 1'b1;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = (ld_state_q == LD_DONE);
  assign cpu_rst_n = (ld_state_q == LD_DONE);
  assign error     = (ld_state_q == LD_ERROR);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives UART frames, scoreboards expected writes
// and checks status outputs for normal, empty, oversize, framing and glitch cases.
module tb_imem_uart_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          cpu_rst_n;
  logic          error;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  logic we_prev = 1'b0;
  logic done_prev = 1'b0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_e;

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .cpu_rst_n(cpu_rst_n),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every we pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (we) begin
        check_eq("we_width", 32'(we_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("we_unexpected", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_eq("waddr", 32'(waddr), 32'(exp_e[35:32]));
          check_eq("wdata", wdata, exp_e[31:0]);
        end
        $display("write addr=%0h data=%08h", waddr, wdata);
        wr_count++;
        last_we_cyc = cyc;
      end
      if (done && !done_prev && wr_count > 0)
        check_eq("done_latency", 32'(cyc - last_we_cyc), 32'd1);
      we_prev   = we;
      done_prev = done;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx    = 1'b1;
    exp_q.delete();
    wr_count = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    $display("sent byte %02h stop=%0d", b, stop_bit);
  endtask

  task automatic push_word(input logic [3:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send_word(input logic [31:0] d);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic wait_for(input string tag, input int lim, input bit want_error);
    int n = 0;
    while (!(want_error ? error : done) && n < lim) begin
      @(posedge clk);
      n++;
    end
    #1 check_eq(tag, 32'(want_error ? error : done), 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    rx    = 1'b1;

    // Reset state and quiet idle line
    do_reset();
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_waddr", 32'(waddr), 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    repeat (200) @(posedge clk);
    #1 check_eq("idle_no_we", 32'(wr_count), 32'd0);

    // Two-word load
    push_word(4'd0, 32'h00A00513);
    push_word(4'd1, 32'h00100593);
    send_byte(8'h02, 1'b1);
    check_eq("busy_during_load", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b1);
    send_word(32'h00A00513);
    send_word(32'h00100593);
    wait_for("two_word_done", 60, 1'b0);
    check_eq("two_word_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check_eq("two_word_busy", 32'(busy), 32'd0);
    check_eq("two_word_count", 32'(wr_count), 32'd2);
    check_eq("two_word_hold_wdata", wdata, 32'h00100593);

    // Asynchronous reset in the middle of a frame
    @(posedge clk); #1 rx = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_done", 32'(done), 32'd0);
    check_eq("async_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("async_rst_wdata", wdata, 32'd0);
    check_eq("async_rst_waddr", 32'(waddr), 32'd0);
    do_reset();

    // Empty image, then a stray byte
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_for("empty_done", 20, 1'b0);
    check_eq("empty_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    send_byte(8'hFF, 1'b1);
    check_eq("empty_after_done", 32'(done), 32'd1);
    check_eq("empty_no_we", 32'(wr_count), 32'd0);
    check_eq("empty_no_error", 32'(error), 32'd0);

    // Oversize length
    do_reset();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_for("over_error", 20, 1'b1);
    check_eq("over_done", 32'(done), 32'd0);
    check_eq("over_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("over_busy", 32'(busy), 32'd0);
    check_eq("over_no_we", 32'(wr_count), 32'd0);

    // Full-capacity image
    do_reset();
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      push_word(4'(i), w);
      send_word(w);
    end
    wait_for("full_done", 60, 1'b0);
    check_eq("full_count", 32'(wr_count), 32'd16);
    check_eq("full_last_waddr", 32'(waddr), 32'hF);
    check_eq("full_hold_wdata", wdata, w);
    check_eq("full_queue_empty", 32'(exp_q.size()), 32'd0);

    // Framing error on the third data byte
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    wait_for("frame_error", 20, 1'b1);
    send_byte(8'hDD, 1'b1);
    check_eq("frame_no_we", 32'(wr_count), 32'd0);
    check_eq("frame_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check_eq("frame_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_eq("frame_rst_clears", 32'(error), 32'd0);
    do_reset();

    // One-cycle glitch in idle, then a valid one-word image
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("glitch_no_error", 32'(error), 32'd0);
    check_eq("glitch_no_busy", 32'(busy), 32'd0);
    push_word(4'd0, 32'h12345678);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_word(32'h12345678);
    wait_for("glitch_done", 60, 1'b0);
    check_eq("glitch_count", 32'(wr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
